// File: rtl/dsel_rd_pkg.sv
// Shared definitions for the dsel read engine: FSM encodings and parameter defaults.
package dsel_rd_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   localparam int DEF_AWIDTH     = 32;
   localparam int DEF_DWIDTH     = 32;
   localparam int DEF_LEN_WIDTH  = 16;
   localparam int DEF_RD_LAT     = 1;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/dsel_rd_if.sv
// Bus bundle for the read engine: dsel read port plus the outgoing valid/ready stream.
interface dsel_rd_if
   import dsel_rd_pkg::*;
#(
   parameter int AW = DEF_AWIDTH,
   parameter int DW = DEF_DWIDTH
);

   logic [AW-1:0] dsel_in_addr;
   logic          dsel_in_en;
   logic [DW-1:0] dsel_out;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output dsel_in_addr, dsel_in_en, out_valid, out_data, out_last,
      input  dsel_out, out_ready
   );

   modport slave (
      input  dsel_in_addr, dsel_in_en, out_valid, out_data, out_last,
      output dsel_out, out_ready
   );

endinterface

// File: rtl/dsel_rd_fifo.sv
// Synchronous FIFO, power-of-two depth; a pop frees a slot for a push in the same cycle.
module dsel_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Credits upstream make this unreachable; firing means the credit math is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/dsel_rd_engine.sv
// Read-side burst initiator: issues credit-limited sequential reads and streams the results.
// Optional burst XOR checksum is built when DSEL_RD_CSUM_EN is defined.
module dsel_rd_engine
   import dsel_rd_pkg::*;
#(
   parameter int LOC_AWIDTH = DEF_AWIDTH,
   parameter int LOC_DWIDTH = DEF_DWIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
   parameter int RD_LAT     = DEF_RD_LAT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LOC_AWIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic [LOC_DWIDTH-1:0] csum,
   dsel_rd_if.master             bus
);

   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int CW1 = CW + 1;

   typedef struct packed {
      logic                  last;
      logic [LOC_DWIDTH-1:0] data;
   } ent_t;

   state_t                state;
   logic [LEN_WIDTH-1:0]  len_r, issued;
   logic [LOC_AWIDTH-1:0] addr_r;
   logic [CW-1:0]         inflight, fifo_count;
   logic [CW1-1:0]        credit_used;
   logic [RD_LAT:0]       vld_pipe, last_pipe;
   logic                  issue_nxt, last_nxt, capture, pop;
   logic                  fifo_full, fifo_empty;
   ent_t                  wr_ent, rd_ent;

   // vld_pipe[0] is the registered read enable itself; the tail marks the capture cycle.
   assign capture     = vld_pipe[RD_LAT];
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};

   always_comb begin
      issue_nxt = 1'b0;
      last_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            issue_nxt = start && (len != '0);
            last_nxt  = (len == LEN_WIDTH'(1));
         end
         ST_RUN: begin
            issue_nxt = (issued != len_r) && (credit_used < CW1'(FIFO_DEPTH));
            last_nxt  = ((issued + LEN_WIDTH'(1)) == len_r);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         len_r     <= '0;
         issued    <= '0;
         addr_r    <= '0;
         inflight  <= '0;
         vld_pipe  <= '0;
         last_pipe <= '0;
         done      <= 1'b0;
      end else begin
         done      <= 1'b0;
         vld_pipe  <= {vld_pipe[RD_LAT-1:0], issue_nxt};
         last_pipe <= {last_pipe[RD_LAT-1:0], issue_nxt && last_nxt};
         inflight  <= inflight + CW'(issue_nxt) - CW'(capture);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state  <= ST_RUN;
                     len_r  <= len;
                     issued <= LEN_WIDTH'(1);
                     addr_r <= base_addr;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (issue_nxt) begin
                  issued <= issued + LEN_WIDTH'(1);
                  addr_r <= addr_r + LOC_AWIDTH'(1);
               end
               // The final read is on the port this cycle; only draining remains.
               if (issued == len_r) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && rd_ent.last) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign wr_ent = '{last: last_pipe[RD_LAT], data: bus.dsel_out};

   dsel_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(ent_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (capture),
      .wr_data (wr_ent),
      .pop     (pop),
      .rd_data (rd_ent),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Stale storage is masked so an empty FIFO presents all-zero outputs.
   assign pop              = bus.out_valid && bus.out_ready;
   assign bus.out_valid    = !fifo_empty;
   assign bus.out_data     = fifo_empty ? '0 : rd_ent.data;
   assign bus.out_last     = !fifo_empty && rd_ent.last;
   assign bus.dsel_in_en   = vld_pipe[0];
   assign bus.dsel_in_addr = addr_r;
   assign busy             = (state == ST_RUN) || (state == ST_DRAIN);

`ifdef DSEL_RD_CSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       csum <= '0;
      else if (state == ST_IDLE && start) csum <= '0;
      else if (pop)                     csum <= csum ^ bus.out_data;
   end
`else
   assign csum = '0;
`endif

endmodule

// File: tb/tb_dsel_rd_engine.sv
// Scoreboard bench for dsel_rd_engine: random bursts against a queue-based burst model.
module tb_dsel_rd_engine;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done;
  logic [31:0] csum;

  dsel_rd_if bus ();

  dsel_rd_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .csum      (csum),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  exp_t        mon_e;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int issued_cnt = 0, acc_cnt = 0, done_cnt = 0;
  int first_en = -1, last_en = -1, first_vld = -1, last_acc = -1;
  int rmode = 0, hold_until = 0;
  bit tbl_on = 1'b0;
  logic [31:0] tbl [4];
  logic [31:0] csum_exp = '0;
  logic        stall_prev = 1'b0, last_prev = 1'b0;
  logic [31:0] data_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Contents of the memory behind dsel_data_handle.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (tbl_on && a < 32'd3) return tbl[a[1:0]];
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ (a * 32'h9E37_79B1);
  endfunction

  // One-cycle read latency model.
  always @(posedge clk)
    bus.dsel_out <= bus.dsel_in_en ? mem_word(bus.dsel_in_addr) : $urandom;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc >= hold_until);
      endcase
    end
  end

  // Monitor: checks every read address issued and every word accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dsel_in_en) begin
        issued_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (addr_q.size() == 0) chk("spurious_read", 1, 0);
        else chk("read_addr", bus.dsel_in_addr, addr_q.pop_front());
        chk("credit_bound", 64'((issued_cnt - acc_cnt) <= DEPTH), 1);
      end
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_word", {bus.out_last, bus.out_data}, {last_prev, data_prev});
      end
      if (bus.out_valid && first_vld < 0) first_vld = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("out_data", bus.out_data, mon_e.data);
          chk("out_last", bus.out_last, mon_e.last);
        end
        acc_cnt++;
        last_acc = cyc;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      last_prev  = bus.out_last;
      if (done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rd_en"}, bus.dsel_in_en, 0);
    chk({nm, "_rd_addr"}, bus.dsel_in_addr, 0);
    chk({nm, "_valid"}, bus.out_valid, 0);
    chk({nm, "_data"}, bus.out_data, 0);
    chk({nm, "_last"}, bus.out_last, 0);
    chk({nm, "_csum"}, csum, 0);
  endtask

  task automatic start_burst(input logic [31:0] b, input int n, output int t0);
    logic [31:0] a, w;
    issued_cnt = 0; acc_cnt = 0;
    first_en = -1; last_en = -1; first_vld = -1;
    csum_exp = '0;
    for (int i = 0; i < n; i++) begin
      a = b + 32'(i);
      w = mem_word(a);
      exp_q.push_back('{data: w, last: (i == n - 1)});
      addr_q.push_back(a);
      csum_exp ^= w;
    end
    base_addr = b;
    len       = 16'(n);
    start     = 1'b1;
    t0        = cyc;
    tick();
    start     = 1'b0;
    base_addr = $urandom;
    len       = 16'($urandom);
  endtask

  task automatic finish_burst(input string nm);
    bit got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk); #1;
      got = done;
    end
    if (!got) begin
      chk({nm, "_done_timeout"}, 0, 1);
      return;
    end
    chk({nm, "_done_after_last"}, 64'(cyc - last_acc), 1);
    chk({nm, "_busy_at_done"}, busy, 0);
    chk({nm, "_words_left"}, 64'(exp_q.size()), 0);
`ifdef DSEL_RD_CSUM_EN
    chk({nm, "_csum"}, csum, csum_exp);
`else
    chk({nm, "_csum_off"}, csum, 0);
`endif
    @(negedge clk); #1;
    chk({nm, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int t0, dc, n;
    logic [31:0] b;

    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic burst, latency and back-to-back issue.
    rmode = 0; tick();
    start_burst(32'h10, 4, t0);
    finish_burst("t1");
    chk("t1_first_en_lat", 64'(first_en - t0), 1);
    chk("t1_first_valid_lat", 64'(first_vld - t0), 3);
    chk("t1_issue_span", 64'(last_en - first_en), 3);

    // Backpressure: only FIFO_DEPTH reads outstanding.
    rmode = 2; hold_until = cyc + 11; tick();
    start_burst(32'h100, 8, t0);
    repeat (7) @(negedge clk);
    #1;
    chk("t2_stall_issued", 64'(issued_cnt), DEPTH);
    chk("t2_stall_accepted", 64'(acc_cnt), 0);
    chk("t2_stall_en", bus.dsel_in_en, 0);
    chk("t2_stall_busy", busy, 1);
    finish_burst("t2");

    // Address wrap with random backpressure.
    rmode = 1; tick();
    start_burst(32'hFFFF_FFFE, 4, t0);
    finish_burst("t3");

    // Zero-length start.
    rmode = 0; tick();
    dc = done_cnt;
    start_burst(32'h40, 0, t0);
    @(negedge clk); #1;
    chk("t4_zero_done", done, 1);
    chk("t4_zero_busy", busy, 0);
    @(negedge clk); #1;
    chk("t4_zero_done_pulse", done, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("t4_zero_no_reads", 64'(issued_cnt), 0);
    chk("t4_zero_done_count", 64'(done_cnt - dc), 1);

    // Start while busy is ignored.
    rmode = 2; hold_until = cyc + 12; tick();
    dc = done_cnt;
    start_burst(32'h200, 6, t0);
    tick();
    base_addr = 32'h900; len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    finish_burst("t4b");
    chk("t4b_done_count", 64'(done_cnt - dc), 1);

    // Reset mid-burst.
    rmode = 0; tick();
    start_burst(32'h300, 6, t0);
    for (int t = 0; t < 100 && acc_cnt < 2; t++) begin
      @(negedge clk); #1;
    end
    #1;
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check_zero("t5_reset");
    exp_q.delete();
    addr_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", 64'(done_cnt - dc), 0);
    chk("t5_idle", busy, 0);
    rmode = 1; tick();
    start_burst(32'h380, 5, t0);
    finish_burst("t5b");

    // Single-word and random bursts.
    start_burst(32'h55, 1, t0);
    finish_burst("len1");
    for (int k = 0; k < 8; k++) begin
      rmode = $urandom_range(0, 1);
      b = $urandom;
      n = $urandom_range(1, 12);
      tick();
      start_burst(b, n, t0);
      finish_burst("rand");
    end

    // Checksum pattern.
    tbl_on = 1'b1;
    tbl[0] = 32'hA5A5_0000; tbl[1] = 32'h0000_5A5A; tbl[2] = 32'hFFFF_FFFF; tbl[3] = '0;
    rmode = 1; tick();
    start_burst(32'h0, 3, t0);
    finish_burst("t6");
    repeat (3) tick();
`ifdef DSEL_RD_CSUM_EN
    chk("t6_csum_hold", csum, 32'h5A5A_A5A5);
`else
    chk("t6_csum_off", csum, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
